// File: rtl/gate_pkg.sv
// Shared encodings and vector helpers for the gate truth-table checker.
package gate_pkg;

   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_NOT  = 3'd2;
   localparam logic [2:0] GATE_NAND = 3'd3;
   localparam logic [2:0] GATE_NOR  = 3'd4;
   localparam logic [2:0] GATE_XOR  = 3'd5;
   localparam logic [2:0] GATE_XNOR = 3'd6;
   localparam logic [2:0] GATE_BAD  = 3'd7;

   localparam int unsigned NV_2IN = 4;
   localparam int unsigned NV_NOT = 2;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCheck,
      StDone
   } state_e;

   // Index of the final vector for the selected gate.
   function automatic logic [1:0] last_idx(input logic [2:0] sel);
      return (sel == GATE_NOT) ? 2'(NV_NOT - 1) : 2'(NV_2IN - 1);
   endfunction

   // Gate inputs {a, b} for vector idx; NOT drives a from idx[0] and holds b low.
   function automatic logic [1:0] vec_ab(input logic [2:0] sel, input logic [1:0] idx);
      return (sel == GATE_NOT) ? {idx[0], 1'b0} : idx;
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the supported 1- and 2-input gates.
module gate_ref_model
   import gate_pkg::*;
(
   input  logic [2:0] sel,
   input  logic       a,
   input  logic       b,
   output logic       exp_y
);

   // Truth table per gate; illegal selections predict 0.
   always_comb begin
      exp_y = 1'b0;
      case (sel)
         GATE_AND:  exp_y = a & b;
         GATE_OR:   exp_y = a | b;
         GATE_NOT:  exp_y = ~a;
         GATE_NAND: exp_y = ~(a & b);
         GATE_NOR:  exp_y = ~(a | b);
         GATE_XOR:  exp_y = a ^ b;
         GATE_XNOR: exp_y = ~(a ^ b);
         default:   exp_y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_truth_checker.sv
// Drives every input combination into a gate, lets it settle, and scores its
// output against the golden model.
module gate_truth_checker
   import gate_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       dut_y,
   output logic       dut_a,
   output logic       dut_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       bad_sel,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_e     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] ab_q, ab_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic       bad_q, bad_d;
   logic [2:0] err_q, err_d;
   logic [3:0] fail_q, fail_d;
   logic       exp_y;

   gate_ref_model u_ref (
      .sel   (sel_q),
      .a     (ab_q[1]),
      .b     (ab_q[0]),
      .exp_y (exp_y)
   );

   // State and scoreboard registers; reset clears everything including gate inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= 3'd0;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         ab_q    <= 2'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         bad_q   <= 1'b0;
         err_q   <= 3'd0;
         fail_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ab_q    <= ab_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state, vector sequencing and result scoring.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ab_d    = ab_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      bad_d   = bad_q;
      err_d   = err_q;
      fail_d  = fail_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               sel_d  = gate_sel;
               err_d  = 3'd0;
               fail_d = 4'd0;
               done_d = 1'b0;
               pass_d = 1'b0;
               bad_d  = 1'b0;
               if (gate_sel == GATE_BAD) begin
                  // Abort immediately; gate inputs keep their previous values.
                  state_d = StDone;
                  bad_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = StWait;
                  idx_d   = 2'd0;
                  cnt_d   = 4'd0;
                  busy_d  = 1'b1;
                  ab_d    = vec_ab(gate_sel, 2'd0);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == SETTLE_M1) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            // Case inequality so an undriven or X output scores as a failure.
            if (dut_y !== exp_y) begin
               fail_d[idx_q] = 1'b1;
               err_d         = err_q + 3'd1;
            end
            if (idx_q == last_idx(sel_q)) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == 3'd0);
            end else begin
               state_d = StWait;
               idx_d   = idx_q + 2'd1;
               cnt_d   = 4'd0;
               ab_d    = vec_ab(sel_q, idx_q + 2'd1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign dut_a     = ab_q[1];
   assign dut_b     = ab_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign bad_sel   = bad_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Self-checking stimulus/response stage that sits directly upstream and downstream of a single 1- or 2-input logic gate (AND, OR, NOT, NAND, NOR, XOR, XNOR).
- On start, drives every input combination into the gate, waits a settle interval, then samples the gate output and compares it against a golden model.
- Records per-vector failures and an error count, then raises done/pass.
- Replaces hand-written per-gate stimulus sequences with one reusable, synthesizable exerciser.

Parameters:
SETTLE, 1, cycles to hold each vector before sampling dut_y; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse or level; begins a run when idle or done
gate_sel  input  3  0=AND 1=OR 2=NOT 3=NAND 4=NOR 5=XOR 6=XNOR 7=illegal
dut_y  input  1  output of gate under test
dut_a  output  1  gate input a
dut_b  output  1  gate input b (held 0 for NOT)
busy  output  1  run in progress
done  output  1  run finished; results valid
pass  output  1  done and no mismatches and gate_sel legal
bad_sel  output  1  run aborted on gate_sel=7
err_count  output  3  number of mismatching vectors, 0..4
fail_vec  output  4  bit i set if vector i mismatched

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset, asynchronous and usable at any time including mid-run: state goes to IDLE, and every output (dut_a, dut_b, busy, done, pass, bad_sel, err_count, fail_vec) goes to 0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE, start=1 at an edge:
  - latch gate_sel into sel_q; clear err_count, fail_vec, done, pass and bad_sel.
  - if gate_sel=7: go to DONE with bad_sel=1 and pass=0.
  - otherwise: idx=0, cnt=0, busy=1, go to WAIT.
- Vector mapping:
  - 2-input gates: idx 0..3; dut_a=idx[1], dut_b=idx[0].
  - NOT: idx 0..1; dut_a=idx[0], dut_b=0.
  - dut_a and dut_b are registered and change on the same edge as idx.
- WAIT: cnt increments each cycle. When cnt=SETTLE-1, go to CHECK.
- CHECK (one cycle):
  - expected = golden(sel_q, dut_a, dut_b). dut_y is sampled at the edge leaving CHECK.
  - Mismatch means dut_y !== expected, so X/Z counts as a fail. On mismatch set fail_vec[idx] and increment err_count.
  - If idx=last: go to DONE with busy=0 and done=1. pass=1 iff the final err_count is 0, including this cycle's result.
  - Otherwise: idx+1, cnt=0, go to WAIT.
- Latency: done rises exactly NV*(SETTLE+1) edges after the start-capture edge, where NV=4 for 2-input gates and NV=2 for NOT.
- DONE: all results held stable. start=1 re-arms exactly as from IDLE, clearing results on that edge.
- start during WAIT/CHECK is ignored. gate_sel changes after capture are ignored.
- dut_a/dut_b hold their last vector in DONE and return to 0 only on reset.
- err_count saturates implicitly: it cannot exceed 4.

Decomposition:
- Package gate_pkg holds:
  - gate_sel encodings as localparams (GATE_AND..GATE_XNOR, GATE_BAD=7)
  - the state encoding
  - NV_2IN=4 and NV_NOT=2
- Sub-module gate_ref_model: purely combinational golden model; inputs sel, a, b; output exp_y; exp_y=0 for illegal sel.
- The checker FSM, counters and scoreboard registers live in gate_truth_checker.

Test Plan:
- Correct XOR DUT, gate_sel=5, SETTLE=1, start pulse -> dut_a/dut_b sequence 00,01,10,11; done at start edge+8; pass=1, err_count=0, fail_vec=0000.
- gate_sel=0 (AND) with an OR gate wired as DUT -> vectors 1 and 2 fail; err_count=2, fail_vec=0110, pass=0.
- NOT gate, gate_sel=2, SETTLE=3 -> only 2 vectors, dut_b stays 0; done at start edge+8; pass=1.
- gate_sel=7 -> done on the edge after start; bad_sel=1, pass=0, busy never asserts.
- rst_n dropped mid-WAIT of vector 2 -> outputs immediately 0 and state IDLE. After release, a new start for NAND (gate_sel=3) with a correct DUT -> pass=1.
- start held high through an entire run, then deasserted; second start in DONE -> results cleared on the capture edge, second run completes identically; mid-run start toggles have no effect.
